// File: rtl/bip_pkg.sv
// Shared opcodes, select encodings and FSM state type for the accumulator
// processor control unit.
package bip_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned IMM_W    = 11;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control-strobe map; every output is zero unless run
// is high, so IDLE/HALTED cycles never disturb the datapath.
module bip_decoder
  import bip_pkg::*;
(
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          sel_a_c,
  output logic                sel_b_c,
  output logic                alu_op_c,
  output logic                wr_acc_c,
  output logic                wr_ram_c,
  output logic                rd_ram_c
);

  always_comb begin
    sel_a_c  = SEL_A_RAM;
    sel_b_c  = SEL_B_RAM;
    alu_op_c = ALU_ADD;
    wr_acc_c = 1'b0;
    wr_ram_c = 1'b0;
    rd_ram_c = 1'b0;
    if (run) begin
      unique case (opcode)
        OP_STO: wr_ram_c = 1'b1;
        OP_LD: begin
          rd_ram_c = 1'b1;
          wr_acc_c = 1'b1;
        end
        OP_LDI: begin
          sel_a_c  = SEL_A_IMM;
          wr_acc_c = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          rd_ram_c = 1'b1;
          sel_a_c  = SEL_A_ALU;
          alu_op_c = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
          wr_acc_c = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          sel_a_c  = SEL_A_ALU;
          sel_b_c  = SEL_B_IMM;
          alu_op_c = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
          wr_acc_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// Fetch/decode control for the accumulator processor: PC, IDLE/RUN/HALTED FSM
// and decode strobes. Define BIP_CYCLE_COUNT_EN to build the executed-cycle counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned addr_bus  = 11,
  parameter int unsigned data_size = 16,
  parameter int unsigned CYC_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [data_size-1:0] Instr,
  output logic [addr_bus-1:0]  PcAddr,
  output logic [data_size-1:0] Operand,
  output logic [addr_bus-1:0]  RamAddr,
  output logic [1:0]           SelA,
  output logic                 SelB,
  output logic                 AluOp,
  output logic                 WrAcc,
  output logic                 WrRam,
  output logic                 RdRam,
  output logic                 Halted,
  output logic [CYC_W-1:0]     Cycles
);

  state_e                state_q, state_d;
  logic [addr_bus-1:0]   pc_d;
  logic [OPCODE_W-1:0]   opcode;
  logic                  run;

  assign opcode  = Instr[data_size-1 -: OPCODE_W];
  assign run     = (state_q == ST_RUN);
  assign Halted  = (state_q == ST_HALTED);
  assign Operand = {{(data_size-IMM_W){Instr[IMM_W-1]}}, Instr[IMM_W-1:0]};
  assign RamAddr = Instr[addr_bus-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      PcAddr  <= '0;
    end else begin
      state_q <= state_d;
      PcAddr  <= pc_d;
    end
  end

  // PC wraps naturally at 2^addr_bus; HLT freezes it on the HLT address.
  always_comb begin
    state_d = state_q;
    pc_d    = PcAddr;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (opcode == OP_HLT) state_d = ST_HALTED;
        else                  pc_d    = PcAddr + addr_bus'(1);
      end
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

`ifdef BIP_CYCLE_COUNT_EN
  // Saturating count of RUN cycles, HLT cycle included.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Cycles <= '0;
    end else if (Halted && Start) begin
      Cycles <= '0;
    end else if (run && (Cycles != '1)) begin
      Cycles <= Cycles + CYC_W'(1);
    end
  end
`else
  assign Cycles = '0;
`endif

  bip_decoder u_decoder (
    .run      (run),
    .opcode   (opcode),
    .sel_a_c  (SelA),
    .sel_b_c  (SelB),
    .alu_op_c (AluOp),
    .wr_acc_c (WrAcc),
    .wr_ram_c (WrRam),
    .rd_ram_c (RdRam)
  );

endmodule

// File: doc/bip_control.md
# bip_control

Instruction fetch/decode control unit for the accumulator processor. It owns the program counter, drives the program memory address, and decodes the 16-bit instruction word it returns (5-bit opcode, 11-bit operand). It issues the accumulator, ALU and data-RAM control strobes, and stops on HLT. It sits directly downstream of the program memory and upstream of the datapath and data RAM.

## Interface
- addr_bus, 11, program/data address width
- data_size, 16, instruction and data word width
- CYC_W, 16, cycle-counter width
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Start  in  1  single-cycle pulse that starts or restarts execution from address 0
- Instr  in  data_size  instruction word from program memory (combinational read of PcAddr)
- PcAddr  out  addr_bus  program counter, to program memory Addr
- Operand  out  data_size  Instr[10:0] sign-extended to data_size
- RamAddr  out  addr_bus  Instr[10:0], data RAM address
- SelA  out  2  accumulator source: 0 = RAM, 1 = immediate, 2 = ALU
- SelB  out  1  ALU B operand: 0 = RAM, 1 = immediate
- AluOp  out  1  0 = add, 1 = subtract
- WrAcc  out  1  accumulator write enable
- WrRam  out  1  data RAM write enable
- RdRam  out  1  data RAM read enable
- Halted  out  1  high in HALTED state
- Cycles  out  CYC_W  executed-instruction count

## Operation
- States: IDLE, RUN, HALTED.
- IDLE: entered on Reset. Start moves the block to RUN. PC = 0.
- RUN: one instruction per cycle. PC increments by 1 every clock except on HLT.
- HLT (opcode 0) in RUN: next state is HALTED. PC holds at the HLT address.
- HALTED: Start loads PC = 0 and moves to RUN. All other inputs are ignored.
- Decode applies only in RUN. In IDLE and HALTED, every strobe (WrAcc, WrRam, RdRam) is 0 and SelA/SelB/AluOp are 0.
- Opcode decode:
  - STO (1): WrRam.
  - LD (2): RdRam, SelA = 0, WrAcc.
  - LDI (3): SelA = 1, WrAcc.
  - ADD (4): RdRam, SelA = 2, SelB = 0, AluOp = 0, WrAcc.
  - ADDI (5): SelA = 2, SelB = 1, AluOp = 0, WrAcc.
  - SUB (6): as ADD with AluOp = 1.
  - SUBI (7): as ADDI with AluOp = 1.
  - Opcodes 8–31: NOP. No strobes; PC advances.
- PC wrap-around: at 2^addr_bus − 1 with a non-HLT instruction, PC becomes 0 and execution continues.
- Operand sign extension: Instr[10] replicated into bits [data_size-1:11]. Example: 0x7FF gives 0xFFFF, 0x0FF gives 0x00FF.
- Start while already in RUN has no effect.
- Reset overrides Start when both are high in the same cycle.

## Timing
- Reset values:
  - PcAddr = 0, Cycles = 0, Halted = 0, state = IDLE.
  - All decode outputs are 0.
  - Operand and RamAddr follow Instr combinationally and are not gated.
- Start sampled at edge n: RUN from cycle n+1, and the instruction at address 0 is decoded in cycle n+1.
- Control outputs are combinational from Instr and state. Zero latency within the cycle.
- The datapath commits on the edge that ends the cycle.
- HLT decoded in cycle k: Halted = 1 from cycle k+1. The HLT cycle itself issues no strobes.
- Reset mid-RUN: the next cycle is IDLE with PC = 0. No strobe is emitted in that cycle.

## Configuration
- BIP_CYCLE_COUNT_EN defined:
  - Cycles increments once per RUN cycle, including the HLT cycle.
  - Cycles saturates at 2^CYC_W − 1.
  - Start from HALTED clears Cycles to 0.
- BIP_CYCLE_COUNT_EN undefined:
  - Cycles is tied to 0 and no counter logic exists.
  - The port remains, so the interface is identical in both builds.

## Structure
- Package bip_pkg holds:
  - opcode localparams (HLT…SUBI)
  - SelA/SelB encodings
  - the state encoding (IDLE, RUN, HALTED)
- Sub-module bip_decoder: purely combinational opcode-to-strobes map, gated by a run input.
- bip_control instantiates bip_decoder and holds the PC, FSM and counter.

## Test plan
- Reset, then Start, against the program LDI 16; STO 1; LD 1; ADDI 255; STO 2; LD 16; HLT:
  - PcAddr runs 0..6.
  - Strobes per the decode list.
  - Operand = 0x00FF at PC 3.
  - Halted = 1 at the cycle after PC 6.
  - With the macro, Cycles = 7.
- Operand 0x400 at LDI → Operand = 0xFC00, SelA = 1, WrAcc = 1.
- SUB 5 → RdRam = 1, SelA = 2, SelB = 0, AluOp = 1, RamAddr = 5.
- PC preloaded via NOPs to 0x7FF → next PcAddr = 0x000, no halt.
- Reset asserted mid-RUN at PC 3 → next cycle IDLE, PcAddr = 0, all strobes 0; Start ignored in the same cycle as Reset.
- In HALTED, Start pulse → PcAddr = 0, RUN, Cycles = 0 then counting; Start held during RUN → no PC reload.
